// File: rtl/bram_writer_pkg.sv
// Shared definitions for the frame BRAM write side: geometry and FSM states.
package bram_writer_pkg;

    localparam int BRAM_ADDR_WIDTH = 15;
    localparam int BRAM_DATA_WIDTH = 64;
    localparam int BRAM_DEPTH      = 2 ** BRAM_ADDR_WIDTH;

    // FILL   : accepting words and writing them at consecutive addresses
    // COMMIT : one idle cycle so the final write reaches the BRAM
    // HOLD   : frame published to the reader, waiting for its acknowledge
    // DROP   : frame exceeded the BRAM; swallow words until the end marker
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2,
        DROP   = 2'd3
    } writer_state_t;

endpackage

// File: rtl/bram_frame_writer.sv
// Writes a valid/ready stream of words into BRAM port A from address 0,
// publishes the frame length to the reader and waits for its acknowledge.
// Oversized frames are discarded and reported with a one-cycle pulse.
module bram_frame_writer
    import bram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = BRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic                  frame_valid,
    output logic [ADDR_WIDTH:0]   frame_len,
    input  logic                  frame_ack,
    output logic                  overflow
);

    // Pointer carries one extra bit so a full-depth frame length fits.
    localparam int                PTR_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = PTR_WIDTH'((2 ** ADDR_WIDTH) - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = PTR_WIDTH'(1);

    writer_state_t         state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic                  s_ready_q, s_ready_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                  bram_we_q, bram_we_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [ADDR_WIDTH:0]   frame_len_q, frame_len_d;
    logic                  overflow_q, overflow_d;
    logic                  beat_accepted;

    assign beat_accepted = s_valid & s_ready_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        bram_we_d     = 1'b0;
        frame_valid_d = frame_valid_q;
        frame_len_d   = frame_len_q;
        overflow_d    = 1'b0;

        unique case (state_q)
            FILL: begin
                if (beat_accepted) begin
                    bram_we_d   = 1'b1;
                    bram_addr_d = wr_ptr_q[ADDR_WIDTH-1:0];
                    bram_din_d  = s_data;
                    wr_ptr_d    = wr_ptr_q + PTR_ONE;
                    if (s_last) begin
                        frame_len_d = wr_ptr_q + PTR_ONE;
                        state_d     = COMMIT;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        // Last slot used and the frame keeps going: give up on it.
                        state_d = DROP;
                    end
                end
            end
            COMMIT: begin
                frame_valid_d = 1'b1;
                state_d       = HOLD;
            end
            HOLD: begin
                if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    wr_ptr_d      = '0;
                    state_d       = FILL;
                end
            end
            DROP: begin
                if (beat_accepted && s_last) begin
                    overflow_d = 1'b1;
                    wr_ptr_d   = '0;
                    state_d    = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // Ready is registered, so derive it from where the FSM is heading.
        s_ready_d = (state_d == FILL) || (state_d == DROP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            wr_ptr_q      <= '0;
            s_ready_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            bram_we_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            s_ready_q     <= s_ready_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            bram_we_q     <= bram_we_d;
            frame_valid_q <= frame_valid_d;
            frame_len_q   <= frame_len_d;
            overflow_q    <= overflow_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign bram_we     = bram_we_q;
    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bram_frame_writer.sv
// Randomized bench for bram_frame_writer with a frame-level reference model.
module tb_bram_frame_writer;

    localparam int AW    = 15;
    localparam int DW    = 64;
    localparam int DEPTH = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic          frame_valid;
    logic [AW:0]   frame_len;
    logic          frame_ack;
    logic          overflow;

    bram_frame_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .frame_valid(frame_valid), .frame_len(frame_len),
        .frame_ack(frame_ack), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;

    wr_t           exp_wr[$];       // writes the model says must appear, in order
    logic [DW-1:0] preset[$];       // fixed words to use before random ones
    logic [DW-1:0] frame_words[$];  // words of the current frame (for readback)
    logic [DW-1:0] mem [0:DEPTH-1]; // stand-in for blk_mem_gen_0
    int            wr_count  = 0;
    int            ovf_count = 0;
    int            fv_rise   = 0;
    logic          fv_prev   = 1'b0;
    logic [AW-1:0] last_wr_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observes BRAM port A and the status outputs once per cycle.
    always @(negedge clk) begin
        if (bram_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 64'(bram_addr), 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", 64'(bram_addr), 64'(e.addr));
                check("wr_data", bram_din, e.data);
            end
            mem[bram_addr] = bram_din;
            last_wr_addr   = bram_addr;
            wr_count++;
        end
        if (overflow) ovf_count++;
        if (frame_valid && !fv_prev) fv_rise++;
        fv_prev = frame_valid;
    end

    // Drive one frame of n words; abort=1 leaves the frame unterminated.
    task automatic send_frame(input int n, input bit gaps, input bit abort);
        logic [DW-1:0] w;
        bit            acc;
        int            tmo;
        wr_t           e;
        frame_words.delete();
        for (int i = 0; i < n; i++) begin
            w = (preset.size() > 0) ? preset.pop_front() : {$urandom, $urandom};
            if (n <= 128) frame_words.push_back(w);
            // Model: word i of a frame lands at address i while it fits.
            if (i < DEPTH) begin
                e.addr = AW'(i);
                e.data = w;
                exp_wr.push_back(e);
            end
            s_data = w;
            s_last = (i == n - 1) && !abort;
            acc = 1'b0;
            tmo = 0;
            while (!acc) begin
                s_valid = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                acc = s_valid && s_ready;
                @(posedge clk);
                @(negedge clk);
                tmo++;
                if (tmo > 1000) begin
                    check("accept_timeout", 64'(tmo), 64'd0);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (abort) return;
        if (n <= DEPTH) begin
            check("commit_s_ready", 64'(s_ready), 64'd0);
            check("commit_fv", 64'(frame_valid), 64'd0);
            @(negedge clk);
            check("fv_rise", 64'(frame_valid), 64'd1);
            check("frame_len", 64'(frame_len), 64'(n));
            check("hold_s_ready", 64'(s_ready), 64'd0);
            check("pending_writes", 64'(exp_wr.size()), 64'd0);
            if (n <= 128) begin
                for (int i = 0; i < n; i++)
                    check("readback", mem[i], frame_words[i]);
            end
        end else begin
            check("ovf_pulse", 64'(overflow), 64'd1);
            check("drop_s_ready", 64'(s_ready), 64'd1);
            @(negedge clk);
            check("ovf_clear", 64'(overflow), 64'd0);
            check("ovf_no_fv", 64'(frame_valid), 64'd0);
            check("pending_writes", 64'(exp_wr.size()), 64'd0);
        end
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_fv_low", 64'(frame_valid), 64'd0);
        check("ack_s_ready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        int n0, f0, o0;
        rst = 1'b1;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_din", bram_din, 64'd0);
        check("rst_fv", 64'(frame_valid), 64'd0);
        check("rst_len", 64'(frame_len), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        check("release_s_ready", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("first_edge_s_ready", 64'(s_ready), 64'd1);

        // Three-word frame with fixed data.
        preset.push_back(64'h11); preset.push_back(64'h22); preset.push_back(64'h33);
        send_frame(3, 1'b0, 1'b0);
        $display("frame: 3 words, frame_len=%0d", frame_len);

        // Hold with the source pushing, then acknowledge.
        n0 = wr_count;
        s_data = 64'hAA;
        s_last = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_ready", 64'(s_ready), 64'd0);
            check("hold_fv", 64'(frame_valid), 64'd1);
            check("hold_len", 64'(frame_len), 64'd3);
        end
        check("hold_no_writes", 64'(wr_count - n0), 64'd0);
        ack_frame();
        preset.push_back(64'hAA);
        send_frame(2, 1'b0, 1'b0);
        $display("frame: 2 words after ack, frame_len=%0d", frame_len);
        ack_frame();

        // Full-depth frame.
        o0 = ovf_count;
        send_frame(DEPTH, 1'b0, 1'b0);
        check("full_last_addr", 64'(last_wr_addr), 64'h7FFF);
        check("full_no_ovf", 64'(ovf_count - o0), 64'd0);
        $display("frame: %0d words, frame_len=%0d", DEPTH, frame_len);
        ack_frame();

        // Oversized frame, then a normal one that must restart at address 0.
        o0 = ovf_count;
        f0 = fv_rise;
        n0 = wr_count;
        send_frame(DEPTH + 2, 1'b0, 1'b0);
        check("ovs_ovf_once", 64'(ovf_count - o0), 64'd1);
        check("ovs_no_fv", 64'(fv_rise - f0), 64'd0);
        check("ovs_write_count", 64'(wr_count - n0), 64'(DEPTH));
        check("ovs_last_addr", 64'(last_wr_addr), 64'h7FFF);
        $display("frame: %0d words dropped, overflow pulses=%0d", DEPTH + 2, ovf_count - o0);
        send_frame(3, 1'b1, 1'b0);
        $display("frame: 3 words after drop, frame_len=%0d", frame_len);
        ack_frame();

        // Reset in the middle of a frame.
        send_frame(5, 1'b0, 1'b1);
        @(negedge clk);
        check("pre_rst_pending", 64'(exp_wr.size()), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        check("mid_rst_we", 64'(bram_we), 64'd0);
        check("mid_rst_addr", 64'(bram_addr), 64'd0);
        check("mid_rst_din", bram_din, 64'd0);
        check("mid_rst_fv", 64'(frame_valid), 64'd0);
        check("mid_rst_len", 64'(frame_len), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 64'(s_ready), 64'd1);
        send_frame(1, 1'b0, 1'b0);
        $display("frame: 1 word after reset, frame_len=%0d", frame_len);
        ack_frame();

        // Back-pressure gaps across a 100-word frame.
        send_frame(100, 1'b1, 1'b0);
        $display("frame: 100 words with gaps, frame_len=%0d", frame_len);
        ack_frame();

        // A few random-length frames with random gaps.
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, 40);
            send_frame(len, 1'($urandom_range(0, 1)), 1'b0);
            $display("frame: %0d random words, frame_len=%0d", len, frame_len);
            ack_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
